// File: rtl/bdpsk_pn_checker_if.sv
// Bit-stream and monitor signals of the BDPSK PN checker.
// master: the bit source / monitor; slave: the checker itself.
interface bdpsk_pn_checker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             bit_en;
  logic             re_in;
  logic             clr_cnt;
  logic             data_out;
  logic             data_valid;
  logic             err_pulse;
  logic             locked;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sat;

  modport master (
    output bit_en, re_in, clr_cnt,
    input  data_out, data_valid, err_pulse, locked, bit_cnt, err_cnt, err_sat
  );

  modport slave (
    input  bit_en, re_in, clr_cnt,
    output data_out, data_valid, err_pulse, locked, bit_cnt, err_cnt, err_sat
  );
endinterface

// File: rtl/bdpsk_pn_checker.sv
// BDPSK receive-side monitor: differential decoder, self-synchronising PN
// checker with lock/unlock hysteresis, and bit/error counters.
module bdpsk_pn_checker #(
  parameter int unsigned       PN_LEN    = 7,
  parameter logic [PN_LEN-1:0] TAP_MASK  = 7'b110_0000,
  parameter int unsigned       LOCK_CNT  = 16,
  parameter int unsigned       WIN_LEN   = 64,
  parameter int unsigned       ERR_LIMIT = 8,
  parameter int unsigned       CNT_W     = 32
) (
  input logic               clk,
  input logic               reset,
  bdpsk_pn_checker_if.slave bus
);

  localparam int unsigned LD_W = $clog2(PN_LEN + 1);
  localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WC_W = $clog2(WIN_LEN + 1);
  localparam int unsigned WE_W = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, LOCKED} state_t;

  state_t state;
  state_t state_n;

  // Receive history and synchroniser bookkeeping
  logic              prev_re;
  logic [PN_LEN-1:0] sr;
  logic [LD_W-1:0]   load_cnt;
  logic [MC_W-1:0]   match_cnt;
  logic [WC_W-1:0]   win_cnt;
  logic [WE_W-1:0]   win_err;

  // Per-bit combinational terms
  logic              d;
  logic              p;
  logic              miss;
  logic [PN_LEN-1:0] sr_ld;
  logic [PN_LEN-1:0] sr_gen;
  logic [WE_W-1:0]   win_err_inc;
  logic              win_hit;
  logic              load_full;
  logic              lock_hit;
  logic              win_end;
  logic [CNT_W-1:0]  err_inc;

  // Next values of the registered outputs
  logic dv_n;
  logic ep_n;
  logic cnt_en;
  logic locked_n;

  // Registered outputs
  logic             data_out_q;
  logic             data_valid_q;
  logic             err_pulse_q;
  logic             locked_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_sat_q;

  // Decode, predict and evaluate the current bit
  always_comb begin
    d           = bus.re_in ^ prev_re;
    p           = ^(sr & TAP_MASK);
    miss        = d ^ p;
    sr_ld       = {sr[PN_LEN-2:0], d};
    sr_gen      = {sr[PN_LEN-2:0], p};
    win_err_inc = win_err + WE_W'(miss);
    win_hit     = (win_err_inc >= WE_W'(ERR_LIMIT));
    load_full   = (load_cnt == LD_W'(PN_LEN - 1));
    lock_hit    = (match_cnt == MC_W'(LOCK_CNT - 1));
    win_end     = (win_cnt == WC_W'(WIN_LEN - 1));
    err_inc     = err_cnt_q + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; the FSM only moves on bit strobes
  always_comb begin
    state_n = state;
    if (bus.bit_en) begin
      case (state)
        IDLE:    state_n = LOAD;
        // an all-zero history would pin the generator at 0, so keep loading
        LOAD:    if (load_full && (sr_ld != '0)) state_n = CHECK;
        CHECK: begin
          if (miss) begin
            state_n = LOAD;
          end else if (lock_hit) begin
            state_n = LOCKED;
          end
        end
        LOCKED:  if (win_hit) state_n = LOAD;
        default: state_n = IDLE;
      endcase
    end
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    dv_n     = bus.bit_en && (state != IDLE);
    ep_n     = bus.bit_en && (state == LOCKED) && miss;
    cnt_en   = bus.bit_en && (state == LOCKED);
    locked_n = (state_n == LOCKED);
  end

  // History register, decoder memory and acquisition/window counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_re   <= 1'b0;
      sr        <= '0;
      load_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
    end else if (bus.bit_en) begin
      prev_re <= bus.re_in;
      case (state)
        IDLE: begin
          load_cnt <= '0;
        end
        LOAD: begin
          sr        <= sr_ld;
          load_cnt  <= load_full ? '0 : load_cnt + LD_W'(1);
          match_cnt <= '0;
        end
        CHECK: begin
          win_cnt <= '0;
          win_err <= '0;
          if (miss) begin
            // the offending bit is the first bit of the new load
            sr        <= sr_ld;
            load_cnt  <= LD_W'(1);
            match_cnt <= '0;
          end else begin
            sr        <= sr_gen;
            match_cnt <= match_cnt + MC_W'(1);
          end
        end
        LOCKED: begin
          sr       <= sr_gen;
          load_cnt <= '0;
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + WC_W'(1);
            win_err <= win_err_inc;
          end
        end
        default: begin
          load_cnt <= '0;
        end
      endcase
    end
  end

  // Bit/error counters; a clear wins over a same-cycle count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      err_sat_q <= 1'b0;
    end else if (bus.clr_cnt) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      err_sat_q <= 1'b0;
    end else begin
      if (cnt_en) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (ep_n) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_inc;
        end
        if ((err_inc == '1) || (err_cnt_q == '1)) begin
          err_sat_q <= 1'b1;
        end
      end
    end
  end

  // Decoded data, strobes and lock indication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      data_valid_q <= dv_n;
      err_pulse_q  <= ep_n;
      locked_q     <= locked_n;
      if (dv_n) begin
        data_out_q <= d;
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.locked     = locked_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_sat    = err_sat_q;

endmodule

// File: tb/tb_bdpsk_pn_checker.sv
// Bench for bdpsk_pn_checker: a 32-bit and a 4-bit counter build share one
// stimulus stream; a queue-based reference model checks every clock, and a
// vector table plus hand sequences pin the key scenarios to fixed numbers.
module tb_bdpsk_pn_checker;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bdpsk_pn_checker_if #(.CNT_W(32)) bus ();
  bdpsk_pn_checker_if #(.CNT_W(4))  sbus ();

  assign sbus.bit_en  = bus.bit_en;
  assign sbus.re_in   = bus.re_in;
  assign sbus.clr_cnt = bus.clr_cnt;

  bdpsk_pn_checker #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  bdpsk_pn_checker #(.CNT_W(4))  dut_s (.clk(clk), .reset(reset), .bus(sbus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // gen holds the last 7 decoded/generated bits, gen[0] oldest; the PN rule
  // x^7+x^6+1 predicts the next bit as (7 back) xor (6 back) = gen[0]^gen[1].
  bit     m_seen, m_verify, m_lock, m_dv, m_ep, m_dout;
  logic   m_prev;
  int     gen[$];
  int     m_loaded, m_matches, m_win_pos, m_win_errs;
  longint m_bits, m_errs;

  task automatic model_reset();
    m_seen = 0; m_verify = 0; m_lock = 0; m_dv = 0; m_ep = 0; m_dout = 0;
    m_prev = 1'b0; gen.delete();
    m_loaded = 0; m_matches = 0; m_win_pos = 0; m_win_errs = 0;
    m_bits = 0; m_errs = 0;
  endtask

  task automatic model_step(input logic en, input logic re, input logic clr);
    int d, pred, zeros;
    m_dv = 0;
    m_ep = 0;
    if (en) begin
      if (!m_seen) begin
        m_seen = 1;
        m_prev = re;
      end else begin
        d = int'(re ^ m_prev);
        m_prev = re;
        m_dv = 1;
        m_dout = d[0];
        pred = (gen.size() == 7) ? (gen[0] ^ gen[1]) : 0;
        if (m_lock) begin
          gen.push_back(pred); void'(gen.pop_front());
          m_win_pos++;
          if (d != pred) begin
            m_win_errs++;
            m_ep = 1;
            if (!clr) m_errs++;
          end
          if (!clr) m_bits++;
          if (m_win_errs >= 8) begin
            m_lock = 0; m_loaded = 0; gen.delete();
          end
          if (m_win_pos == 64) begin
            m_win_pos = 0; m_win_errs = 0;
          end
        end else if (m_verify) begin
          if (d == pred) begin
            gen.push_back(pred); void'(gen.pop_front());
            m_matches++;
            if (m_matches == 16) begin
              m_verify = 0; m_lock = 1; m_win_pos = 0; m_win_errs = 0;
            end
          end else begin
            gen.push_back(d); void'(gen.pop_front());
            m_verify = 0; m_loaded = 1;
          end
        end else begin
          gen.push_back(d);
          if (gen.size() > 7) void'(gen.pop_front());
          m_loaded++;
          if (m_loaded == 7) begin
            zeros = 0;
            foreach (gen[i]) if (gen[i] == 0) zeros++;
            if (zeros == 7) m_loaded = 0;
            else begin m_verify = 1; m_matches = 0; end
          end
        end
      end
    end
    if (clr) begin
      m_bits = 0; m_errs = 0;
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic compare_all();
    check("data_valid", bus.data_valid, m_dv);
    check("data_out", bus.data_out, m_dout);
    check("err_pulse", bus.err_pulse, m_ep);
    check("locked", bus.locked, m_lock);
    check("bit_cnt", bus.bit_cnt, m_bits % (longint'(1) << 32));
    check("err_cnt", bus.err_cnt, sat(m_errs, 32));
    check("err_sat", bus.err_sat, (m_errs >= 64'hFFFF_FFFF) ? 1 : 0);
    check("s_locked", sbus.locked, m_lock);
    check("s_bit_cnt", sbus.bit_cnt, m_bits % 16);
    check("s_err_cnt", sbus.err_cnt, sat(m_errs, 4));
    check("s_err_sat", sbus.err_sat, (m_errs >= 15) ? 1 : 0);
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic tick(input logic en, input logic re, input logic clr);
    bus.bit_en  = en;
    bus.re_in   = re;
    bus.clr_cnt = clr;
    @(posedge clk);
    #1;
    model_step(en, re, clr);
    compare_all();
  endtask

  // ---------------- PN source + differential encoder ----------------
  logic [6:0] pn_s;
  logic       enc;

  task automatic send_bit(input bit flip, input bit clr, input int gap);
    logic d;
    d    = pn_s[6] ^ pn_s[5];
    pn_s = {pn_s[5:0], d};
    enc  = enc ^ d;
    tick(1'b1, enc ^ flip, clr);
    repeat (gap) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.bit_en = 1'b0; bus.re_in = 1'b0; bus.clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pn_s = 7'h7F;
    enc  = 1'b0;
  endtask

  typedef struct {
    int n;
    int flip;
    int clr;
    int e_lock;
    int e_bits;
    int e_errs;
  } vec_t;

  vec_t tbl [0:18];

  initial begin
    tbl = '{
      '{23, 0, 0, 0,   0, 0},  // 1 idle + 7 load + 15 check
      '{ 1, 0, 0, 1,   0, 0},  // 16th match -> locked
      '{98, 0, 0, 1,  98, 0},
      '{ 1, 1, 0, 1,  99, 1},  // one flipped channel bit ...
      '{ 1, 0, 0, 1, 100, 2},  // ... costs two decoded bits
      '{ 1, 0, 1, 1,   0, 0},  // clear with bit_en: bit not counted
      '{ 1, 0, 0, 1,   1, 0},
      '{26, 0, 0, 1,  27, 0},  // run to the end of the 2nd window
      '{ 1, 1, 0, 1,  28, 1},  // flips on alternate bits -> 8 errors in a row
      '{ 1, 0, 0, 1,  29, 2},
      '{ 1, 1, 0, 1,  30, 3},
      '{ 1, 0, 0, 1,  31, 4},
      '{ 1, 1, 0, 1,  32, 5},
      '{ 1, 0, 0, 1,  33, 6},
      '{ 1, 1, 0, 1,  34, 7},
      '{ 1, 0, 0, 0,  35, 8},  // 8th error in window -> unlock
      '{22, 0, 0, 0,  35, 8},
      '{ 1, 0, 0, 1,  35, 8},  // relock 7 + 16 bits later
      '{10, 0, 0, 1,  45, 8}
    };

    apply_reset();

    check("rst_locked", bus.locked, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_bit_cnt", bus.bit_cnt, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    check("rst_err_sat", bus.err_sat, 0);

    // Directed vector table, one bit_en every 8 clocks
    for (int i = 0; i < 19; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        send_bit((k == 0) && (tbl[i].flip != 0), (k == 0) && (tbl[i].clr != 0), 7);
      end
      check($sformatf("tbl[%0d].locked", i), bus.locked, tbl[i].e_lock);
      check($sformatf("tbl[%0d].bit_cnt", i), bus.bit_cnt, tbl[i].e_bits);
      check($sformatf("tbl[%0d].err_cnt", i), bus.err_cnt, tbl[i].e_errs);
    end

    // Asynchronous reset while locked: outputs clear before the next edge
    #2;
    reset = 1'b1;
    #1;
    check("async_locked", bus.locked, 0);
    check("async_bit_cnt", bus.bit_cnt, 0);
    check("async_err_cnt", bus.err_cnt, 0);
    check("async_valid", bus.data_valid, 0);
    apply_reset();

    // Constant-zero input: history stays all-zero, never locks
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b0);
    check("zero_locked", bus.locked, 0);
    check("zero_err_cnt", bus.err_cnt, 0);
    check("zero_valid", bus.data_valid, 1);

    // Saturation: 20 errors spread over windows, 4-bit build stops at 15
    apply_reset();
    for (int i = 0; i < 24; i++) send_bit(1'b0, 1'b0, 0);
    check("sat_locked0", bus.locked, 1);
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 40; k++) send_bit(k == 9, 1'b0, 0);
    end
    check("sat_err32", bus.err_cnt, 20);
    check("sat_err4", sbus.err_cnt, 15);
    check("sat_flag4", sbus.err_sat, 1);
    check("sat_flag32", bus.err_sat, 0);
    check("sat_locked1", bus.locked, 1);
    tick(1'b0, 1'b0, 1'b1);
    check("sat_clr_err4", sbus.err_cnt, 0);
    check("sat_clr_flag4", sbus.err_sat, 0);
    check("sat_clr_locked", bus.locked, 1);

    // Randomised stream: random strobe spacing, channel flips and clears
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        send_bit($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, 0);
      end else begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bdpsk_pn_checker.md
Name: bdpsk_pn_checker

Overview:
Receive-side companion to the BDPSK transmit chain. It consumes the differentially encoded bit stream, one bit per bit-rate strobe, and differentially decodes it. It then self-synchronises a local PN generator to the decoded data and counts bit errors, giving a loop-back/BER monitor for the modulator path. All outputs are registered in the single clk domain.

Parameters:
PN_LEN, 7, LFSR length in bits
TAP_MASK, 7'b110_0000, feedback taps over history register sr (x^7+x^6+1)
LOCK_CNT, 16, consecutive correct predictions required to declare lock
WIN_LEN, 64, error-monitoring window length in checked bits
ERR_LIMIT, 8, errors within one window that force loss of lock
CNT_W, 32, width of bit/error counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
bit_en  in  1  one-clk pulse per received bit (bit-rate strobe)
re_in  in  1  differentially encoded bit, valid when bit_en=1
clr_cnt  in  1  synchronous clear of bit_cnt/err_cnt/err_sat
data_out  out  1  differentially decoded bit
data_valid  out  1  one-clk pulse, data_out valid
err_pulse  out  1  one-clk pulse, checked bit mismatched prediction (LOCKED only)
locked  out  1  1 while state=LOCKED
bit_cnt  out  CNT_W  bits checked while LOCKED
err_cnt  out  CNT_W  errors counted while LOCKED
err_sat  out  1  sticky, err_cnt saturated at all-ones

Behaviour:
- Reset (async, active-high): all outputs 0, prev_re=0, sr=0, state=IDLE, all internal counters 0.
- All actions occur only on clk edges with bit_en=1. Outputs update 1 clk after the bit_en edge. Pulses last exactly 1 clk.
- Differential decode: d = re_in XOR prev_re; prev_re <= re_in on every bit_en.
- History register sr[PN_LEN-1:0]: sr[0] holds the newest bit. Prediction p = XOR-reduce(sr & TAP_MASK).
- IDLE: first bit_en loads prev_re only. No data_valid. Go to LOAD.
- LOAD: shift d into sr (sr <= {sr[PN_LEN-2:0], d}) and count bits. After PN_LEN bits go to CHECK with match_cnt=0. data_valid/data_out are driven for every decoded bit from LOAD onward.
- CHECK: compare d with p, then shift p into sr (local generator free-runs).
  - Mismatch: reload sr from d stream, back to LOAD (bit count 1).
  - Match: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED with win_cnt=0, win_err=0.
- LOCKED: sr <= shift of p. bit_cnt++. On d!=p: err_pulse=1, err_cnt++, win_err++.
  - win_cnt++ each bit. When win_cnt reaches WIN_LEN, win_cnt and win_err restart at 0.
  - If win_err reaches ERR_LIMIT (including on the current bit), go to LOAD on the next bit and drop locked that cycle. bit_cnt/err_cnt hold their values.
- All-zero sr in CHECK/LOCKED is degenerate (p stuck at 0). If sr==0 on entry to CHECK, return to LOAD.
- Counters: bit_cnt wraps modulo 2^CNT_W. err_cnt saturates at all-ones and sets err_sat; err_sat clears only via clr_cnt/reset.
- clr_cnt has priority over a simultaneous bit_en count. The bit in that cycle is not counted, but FSM/sr still advance. clr_cnt does not affect state or locked.
- Reset mid-operation: immediate return to reset values, regardless of state.
- bit_en held high continuously is legal: one bit per clk.

Test Plan:
- Reset then clean stream: drive re_in = diff-encoded x^7+x^6+1 PN (seed 7'h7F), one bit_en every 8 clks -> locked=1 after 1+7+16 bits; err_cnt=0; bit_cnt=N-24 after N bits.
- Single inverted PN bit while locked (re_in flips at one bit): decoding gives 2 consecutive d errors, since the differential decoder doubles the error -> err_cnt=2, two err_pulse, locked stays 1.
- Burst of 8 decoded-bit errors within 64 bits -> locked drops at the 8th error, FSM re-enters LOAD, relocks 7+16 bits after a clean stream resumes; counters retain values.
- All-zero PN input (re_in constant 0) -> never locked; locked=0, err_cnt=0 throughout.
- clr_cnt asserted in the same cycle as bit_en while locked with bit_cnt=100 -> bit_cnt=0 next clk, err_cnt=0, locked unchanged, next bit gives bit_cnt=1.
- Preload err_cnt near saturation (CNT_W=4 build), inject 20 errors across windows -> err_cnt=15, err_sat=1 until clr_cnt; async reset mid-LOCKED -> all outputs 0 within the same cycle.
